// File: rtl/watch_pkg.sv
// Shared encodings and timing helpers for the watch time-setting blocks.
package watch_pkg;

  localparam logic [1:0] FIELD_SEC  = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_HOUR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEL    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
  localparam int unsigned MS_DIV         = CLK_HZ_DEFAULT / 1000;
  localparam int unsigned MS_CNT_W       = $clog2(MS_DIV);

  function automatic int unsigned ms_cnt_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Step the selected field toward hour (up) or toward sec (down), wrapping hour <-> sec.
  function automatic logic [1:0] field_step(input logic [1:0] f, input logic up);
    if (up) return (f == FIELD_HOUR) ? FIELD_SEC : f + 2'd1;
    else    return (f == FIELD_SEC)  ? FIELD_HOUR : f - 2'd1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle registered pulse every CLK_HZ/1000 clocks.
module ms_tick_gen
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned W   = ms_cnt_w(DIV);

  logic [W-1:0] r_cnt;
  logic         r_tick;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(DIV - 1));
  assign tick   = r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting sequencer: button edges -> field selection and inc/dec strobes with
// hold-to-repeat, plus a blink enable for the field being edited.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned HOLD_MS   = 500,
  parameter int unsigned REPEAT_MS = 100,
  parameter int unsigned BLINK_MS  = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [1:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink_on,
  output logic       set_active
);

  localparam int unsigned T_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned BW    = $clog2(BLINK_MS + 1);

  logic w_tick;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  state_t        r_state, w_state_n;
  logic          r_dir_up, w_dir_up_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n, w_tcnt_inc, w_tlim;
  logic [BW-1:0] r_bcnt, w_bcnt_n, w_bcnt_inc;
  logic [3:0]    r_btn, w_btn, w_rise;
  logic [1:0]    w_field_n;
  logic          w_inc_n, w_dec_n, w_active_n, w_force, w_held, w_blink_n;

  // Button vector order: {U, D, L, R}
  assign w_btn      = {btnU, btnD, btnL, btnR};
  assign w_rise     = w_btn & ~r_btn;
  assign w_held     = r_dir_up ? btnU : btnD;
  assign w_tlim     = (r_state == ST_REPEAT) ? TW'(REPEAT_MS) : TW'(HOLD_MS);
  assign w_tcnt_inc = (r_tcnt == '1) ? r_tcnt : r_tcnt + TW'(1);
  assign w_bcnt_inc = (r_bcnt == '1) ? r_bcnt : r_bcnt + BW'(1);

  always_comb begin
    w_state_n  = r_state;
    w_dir_up_n = r_dir_up;
    w_tcnt_n   = r_tcnt;
    w_field_n  = field_sel;
    w_inc_n    = 1'b0;
    w_dec_n    = 1'b0;
    w_active_n = 1'b1;
    w_force    = 1'b0;
    if (!set_en) begin
      w_state_n  = ST_IDLE;
      w_active_n = 1'b0;
      w_force    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_SEL;
          w_field_n = FIELD_SEC;
          w_tcnt_n  = '0;
          w_force   = 1'b1;
        end
        ST_SEL: begin
          if (w_rise[3] || w_rise[2]) begin
            w_dir_up_n = w_rise[3];
            w_inc_n    = w_rise[3];
            w_dec_n    = ~w_rise[3];
            w_state_n  = ST_HOLD;
            w_tcnt_n   = '0;
            w_force    = 1'b1;
          end else if (!btnU && !btnD && (w_rise[1] ^ w_rise[0])) begin
            w_field_n = field_step(field_sel, w_rise[1]);
            w_force   = 1'b1;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!w_held) begin
            w_state_n = ST_SEL;
          end else if (w_tick) begin
            if (w_tcnt_inc >= w_tlim) begin
              w_inc_n   = r_dir_up;
              w_dec_n   = ~r_dir_up;
              w_state_n = ST_REPEAT;
              w_tcnt_n  = '0;
              w_force   = 1'b1;
            end else begin
              w_tcnt_n = w_tcnt_inc;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  // Any strobe, field change, entry or exit restarts the blink phase with the field visible.
  always_comb begin
    w_blink_n = blink_on;
    w_bcnt_n  = r_bcnt;
    if (w_force) begin
      w_blink_n = 1'b1;
      w_bcnt_n  = '0;
    end else if (w_tick) begin
      if (w_bcnt_inc >= BW'(BLINK_MS)) begin
        w_blink_n = ~blink_on;
        w_bcnt_n  = '0;
      end else begin
        w_bcnt_n = w_bcnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dir_up   <= 1'b0;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_btn      <= '0;
      field_sel  <= FIELD_SEC;
      inc_pulse  <= 1'b0;
      dec_pulse  <= 1'b0;
      blink_on   <= 1'b1;
      set_active <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_dir_up   <= w_dir_up_n;
      r_tcnt     <= w_tcnt_n;
      r_bcnt     <= w_bcnt_n;
      r_btn      <= w_btn;
      field_sel  <= w_field_n;
      inc_pulse  <= w_inc_n;
      dec_pulse  <= w_dec_n;
      blink_on   <= w_blink_n;
      set_active <= w_active_n;
    end
  end

endmodule
